// File: rtl/square_wave_generator_pkg.sv
// Shared types and defaults for the square-wave generator slice.
// CLK_HZ lets benches convert half-periods into output frequencies.
package square_wave_generator_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_LOW  = 2'd1,
    RUN_HIGH = 2'd2
  } sqw_state_t;

  localparam int DEF_CNT_W  = 24;
  localparam int DEF_RISE_W = 32;
  localparam int CLK_HZ     = 100_000_000;

endpackage

// File: rtl/sqw_cfg_slot.sv
// Single-entry holding register for a requested half-period.
// Zero half-periods are refused and raise a sticky cfg_error until the next good load.
module sqw_cfg_slot #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] half_period,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             take,
  output logic [CNT_W-1:0] pending,
  output logic             pend_valid,
  output logic             cfg_error
);

  logic accept;

  assign load_ready = ~pend_valid;
  assign accept     = load_valid & load_ready;

  // A take only happens while full and an accept only while empty, so they never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      pend_valid <= 1'b0;
      cfg_error  <= 1'b0;
    end else begin
      if (take) begin
        pend_valid <= 1'b0;
      end
      if (accept) begin
        if (half_period != '0) begin
          pending    <= half_period;
          pend_valid <= 1'b1;
          cfg_error  <= 1'b0;
        end else begin
          cfg_error  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/square_wave_generator.sv
// Programmable 50%-duty square-wave source with boundary-only period changes.
// Phase counter runs 1..cur_half; new half-periods are adopted only where a phase ends.
module square_wave_generator
  import square_wave_generator_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int RISE_W = DEF_RISE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  half_period,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              waveform,
  output logic              active,
  output logic              cfg_error,
  output logic [RISE_W-1:0] rise_count
);

  sqw_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [CNT_W-1:0]  cur_half, cur_half_next;
  logic [CNT_W-1:0]  pending;
  logic              pend_valid;
  logic              take;
  logic              rise_inc;
  logic              at_boundary;
  logic              waveform_q;
  logic [RISE_W-1:0] rise_q;

  sqw_cfg_slot #(
    .CNT_W(CNT_W)
  ) u_cfg_slot (
    .clk        (clk),
    .reset      (reset),
    .half_period(half_period),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .take       (take),
    .pending    (pending),
    .pend_valid (pend_valid),
    .cfg_error  (cfg_error)
  );

  assign at_boundary = (cnt == cur_half);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    cur_half_next = cur_half;
    take          = 1'b0;
    rise_inc      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && pend_valid) begin
          cur_half_next = pending;
          take          = 1'b1;
          cnt_next      = CNT_W'(1);
          state_next    = RUN_LOW;
        end else if (enable && (cur_half != '0)) begin
          cnt_next      = CNT_W'(1);
          state_next    = RUN_LOW;
        end
      end
      RUN_LOW: begin
        if (at_boundary && pend_valid) begin
          cur_half_next = pending;
          take          = 1'b1;
        end
        // Dropping enable while low is safe to honour at once: the line is already low.
        if (!enable) begin
          state_next = IDLE;
        end else if (at_boundary) begin
          state_next = RUN_HIGH;
          cnt_next   = CNT_W'(1);
          rise_inc   = 1'b1;
        end else begin
          cnt_next   = cnt + CNT_W'(1);
        end
      end
      RUN_HIGH: begin
        if (at_boundary) begin
          if (pend_valid) begin
            cur_half_next = pending;
            take          = 1'b1;
          end
          cnt_next   = CNT_W'(1);
          state_next = enable ? RUN_LOW : IDLE;
        end else begin
          cnt_next   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // waveform comes from a flop fed by the next state so the line never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_half   <= '0;
      rise_q     <= '0;
      waveform_q <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      cur_half   <= cur_half_next;
      waveform_q <= (state_next == RUN_HIGH);
      if (rise_inc) begin
        rise_q <= rise_q + RISE_W'(1);
      end
    end
  end

  assign waveform   = waveform_q;
  assign active     = (state != IDLE);
  assign rise_count = rise_q;

endmodule

// File: tb/tb_square_wave_generator.sv
// Random and directed stimulus for square_wave_generator, checked every cycle against
// a phase-countdown reference model; a second instance with an 8-bit rise counter covers wrap.
module tb_square_wave_generator;
  import square_wave_generator_pkg::*;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [23:0] half_period;
  logic        load_valid;

  logic        load_ready, waveform, active, cfg_error;
  logic [31:0] rise_count;
  logic        load_ready8, waveform8, active8, cfg_error8;
  logic [7:0]  rise_count8;

  int tests_run = 0;
  int tests_failed = 0;

  bit          m_running;
  bit          m_level;
  int unsigned m_remaining;
  int unsigned m_cur;
  int unsigned m_q[$];
  bit          m_err;
  logic [31:0] m_rises;

  square_wave_generator dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .half_period(half_period),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .waveform   (waveform),
    .active     (active),
    .cfg_error  (cfg_error),
    .rise_count (rise_count)
  );

  square_wave_generator #(
    .CNT_W (24),
    .RISE_W(8)
  ) dut8 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .half_period(half_period),
    .load_valid (load_valid),
    .load_ready (load_ready8),
    .waveform   (waveform8),
    .active     (active8),
    .cfg_error  (cfg_error8),
    .rise_count (rise_count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each running phase is a countdown of the current half-period; the slot is a queue.
  task automatic model_step();
    bit pre_pend;
    bit bnd;
    if (reset) begin
      m_running = 0; m_level = 0; m_remaining = 0; m_cur = 0;
      m_q.delete(); m_err = 0; m_rises = '0;
      return;
    end
    pre_pend = (m_q.size() != 0);
    bnd = m_running && (m_remaining == 1);
    if (bnd && pre_pend) m_cur = m_q.pop_front();
    if (!m_running) begin
      if (enable && pre_pend) begin
        m_cur = m_q.pop_front();
        m_running = 1; m_level = 0; m_remaining = m_cur;
      end else if (enable && m_cur != 0) begin
        m_running = 1; m_level = 0; m_remaining = m_cur;
      end
    end else if (!m_level) begin
      if (!enable) m_running = 0;
      else if (bnd) begin
        m_level = 1; m_remaining = m_cur; m_rises = m_rises + 32'd1;
      end else m_remaining--;
    end else begin
      if (bnd) begin
        if (enable) begin
          m_level = 0; m_remaining = m_cur;
        end else begin
          m_running = 0; m_level = 0;
        end
      end else m_remaining--;
    end
    if (load_valid && !pre_pend) begin
      if (half_period != 0) begin
        m_q.push_back(int'(half_period));
        m_err = 0;
      end else m_err = 1;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check_output("waveform",    {31'd0, waveform},    {31'd0, m_running && m_level});
    check_output("active",      {31'd0, active},      {31'd0, m_running});
    check_output("load_ready",  {31'd0, load_ready},  {31'd0, m_q.size() == 0});
    check_output("cfg_error",   {31'd0, cfg_error},   {31'd0, m_err});
    check_output("rise_count",  rise_count,           m_rises);
    check_output("waveform8",   {31'd0, waveform8},   {31'd0, m_running && m_level});
    check_output("active8",     {31'd0, active8},     {31'd0, m_running});
    check_output("load_ready8", {31'd0, load_ready8}, {31'd0, m_q.size() == 0});
    check_output("rise_count8", {24'd0, rise_count8}, {24'd0, m_rises[7:0]});
  end

  task automatic apply_stimulus(input bit rst, input bit en, input bit lv,
                                input logic [23:0] hp, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset       = rst;
      enable      = en;
      load_valid  = lv && (i == 0);
      half_period = hp;
    end
  endtask

  task automatic wait_wave(input logic lvl, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    load_valid = 1'b0;
    while (waveform !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("wait_wave", {31'd0, waveform}, {31'd0, lvl});
  endtask

  initial begin
    bit en_r;
    reset = 1'b1; enable = 1'b0; load_valid = 1'b0; half_period = '0;
    $display("[TB] N=200 gives %0d Hz at the board clock", CLK_HZ / 400);
    apply_stimulus(1, 0, 0, 0, 3);

    // N=2 for 100 periods
    apply_stimulus(0, 1, 1, 2, 1);
    apply_stimulus(0, 1, 0, 2, 404);

    // switch to N=200, then load N=7 in the middle of a high phase
    apply_stimulus(0, 1, 1, 200, 1);
    apply_stimulus(0, 1, 0, 0, 10);
    wait_wave(1, 500);
    apply_stimulus(0, 1, 0, 0, 20);
    apply_stimulus(0, 1, 1, 7, 1);
    apply_stimulus(0, 1, 0, 0, 450);

    // rejected zero load, then N=5
    apply_stimulus(0, 1, 1, 0, 1);
    apply_stimulus(0, 1, 0, 0, 30);
    apply_stimulus(0, 1, 1, 5, 1);
    apply_stimulus(0, 1, 0, 0, 60);

    // N=50, enable dropped 10 cycles into a high phase
    apply_stimulus(0, 1, 1, 50, 1);
    apply_stimulus(0, 1, 0, 0, 30);
    wait_wave(0, 200);
    wait_wave(1, 200);
    apply_stimulus(0, 1, 0, 0, 9);
    apply_stimulus(0, 0, 0, 0, 100);

    // restart with the held half-period, drop enable while low
    apply_stimulus(0, 1, 0, 0, 11);
    apply_stimulus(0, 0, 0, 0, 60);

    // reset in a high phase with a load pending, then re-enable
    apply_stimulus(0, 1, 1, 30, 1);
    apply_stimulus(0, 1, 0, 0, 5);
    wait_wave(1, 100);
    apply_stimulus(0, 1, 1, 9, 1);
    apply_stimulus(0, 1, 0, 0, 5);
    apply_stimulus(1, 1, 0, 0, 1);
    apply_stimulus(0, 1, 0, 0, 50);

    // N=1 for 300 rises, wrapping the 8-bit counter
    apply_stimulus(0, 1, 1, 1, 1);
    apply_stimulus(0, 1, 0, 0, 600);

    // random traffic
    en_r = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
      apply_stimulus($urandom_range(0, 499) == 0, en_r, $urandom_range(0, 15) == 0,
                     24'($urandom_range(0, 12)), 1);
    end
    apply_stimulus(0, 0, 0, 0, 5);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
